registro_historia_y: RTL and testbench
======================================

REGISTRO_HISTORIA_Y -- requirements
Module: registro_historia_y

Interface
REQ-001 SHALL have parameter N, default 25: signed output sample width.
REQ-002 SHALL have parameter W_IN, default 50: signed input width, with W_IN >= N + F.
REQ-003 SHALL have parameter F, default 10: number of fractional LSBs dropped from In (0 allowed).
REQ-004 SHALL have parameter M, default 3: history depth in samples, with M >= 1.
REQ-005 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port In, input, W_IN bits signed: raw accumulator result.
REQ-008 SHALL have port Finish, input, 1 bit: load strobe, one sample per cycle high.
REQ-009 SHALL have port Limpiar, input, 1 bit: synchronous clear of history and flags.
REQ-010 SHALL have port Yk, output, N bits signed: newest stored sample (history slot 0).
REQ-011 SHALL have port Hist, output, M*N bits: slot j at bits [(j+1)*N-1 : j*N], j=0 newest, j=M-1 oldest.
REQ-012 SHALL have port Cuenta, output, clog2(M+1) bits: number of valid slots.
REQ-013 SHALL have port Lleno, output, 1 bit: high when Cuenta == M.
REQ-014 SHALL have port Sat, output, 1 bit: registered pulse, high for the cycle after a load that saturated.
REQ-015 SHALL have port Desborde, output, 1 bit: sticky saturation flag.

Function
REQ-016 Conversion SHALL be an arithmetic right shift of In by F (floor, toward minus infinity), then saturation to N bits, clamping to [-2^(N-1), 2^(N-1)-1].
REQ-017 On a clk edge with Finish=1 and Limpiar=0: slot j SHALL take the value of slot j-1 for j >= 1, and slot 0 SHALL take the converted In.
REQ-018 Latency SHALL be one edge: the value sampled at edge k appears on Yk/Hist after edge k.
REQ-019 With Finish=0 and Limpiar=0, all slots, Cuenta and Desborde SHALL hold their values, and Sat SHALL be 0.
REQ-020 Cuenta SHALL increment on each load and saturate at M; further loads shift history and Cuenta stays at M.
REQ-021 Sat SHALL be set to 1 exactly when the current load clamped; Desborde SHALL be set on the same edge and held until Limpiar or reset.
REQ-022 Limpiar=1 SHALL zero all slots, Cuenta, Sat and Desborde on that edge, and SHALL take priority over a simultaneous Finish (that sample is discarded).
REQ-023 Finish held high for consecutive cycles SHALL load one sample per edge with no gaps.
REQ-024 With M=1, Hist SHALL equal Yk and Lleno SHALL rise after the first load.
REQ-025 Inputs exactly at the limits (shifted value == 2^(N-1)-1 or -2^(N-1)) SHALL pass without setting Sat.

Reset
REQ-026 rst_n low SHALL asynchronously force all slots, Yk, Hist, Cuenta, Lleno, Sat and Desborde to 0.
REQ-027 Reset asserted mid-stream SHALL discard all history; the first Finish after release SHALL load with Cuenta going 0 -> 1.
REQ-028 Release of rst_n SHALL take effect synchronously, and no load SHALL occur on the edge at which rst_n is low.

Structure
REQ-029 Package filtro_pkg SHALL hold the default values of N, W_IN and F, plus the saturation-limit constants derived from N.
REQ-030 Shift-and-saturate SHALL be a combinational sub-module saturador_yk with inputs In and outputs value and clamp flag; the history, counters and flags SHALL reside in registro_historia_y.
REQ-031 No initial blocks SHALL be used; all state SHALL be reset through rst_n.

Verification (bench parameters N=8, W_IN=16, F=4, M=3)
REQ-032 In=16'h0150 with Finish pulse -> Yk=21 next cycle, Cuenta=1, Sat=0.
REQ-033 In=16'hFFEF (-17) load -> Yk=-2 (floor), no saturation; In=16'h7FF0 -> Yk=127, Sat=1 for one cycle, Desborde=1 held; In=16'h8000 -> Yk=-128.
REQ-034 Loads of 16, 32, 48, 64 (converting to 1, 2, 3, 4) on consecutive edges -> after the 3rd load Hist slots {0,1,2}={3,2,1} and Lleno=1; after the 4th load slots={4,3,2} and Cuenta=3.
REQ-035 Finish and Limpiar high on the same edge with In=16'h0010 -> all slots 0, Cuenta=0, Desborde=0; the sample is not stored.
REQ-036 rst_n pulled low between clock edges after two loads -> outputs 0 immediately, without waiting for clk; the next load after release gives Cuenta=1.
REQ-037 In=16'h07F0 (127) and 16'hF800 (-128) -> stored exactly, with Sat=0 and Desborde=0.

Source files
------------

// File: rtl/filtro_pkg.sv
// filtro_pkg: shared defaults for the output history register
// and the saturation limits derived from the default sample width.
package filtro_pkg;

  localparam int N_DEF    = 25;
  localparam int W_IN_DEF = 50;
  localparam int F_DEF    = 10;

  localparam logic signed [N_DEF-1:0] Y_MAX_DEF =
    {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic signed [N_DEF-1:0] Y_MIN_DEF =
    {1'b1, {(N_DEF-1){1'b0}}};

endpackage

// File: rtl/saturador_yk.sv
// saturador_yk: floor shift of the accumulator by F
// followed by clamping to a signed N-bit sample.
module saturador_yk
  import filtro_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int W_IN = W_IN_DEF,
  parameter int F    = F_DEF
) (
  input  logic signed [W_IN-1:0] In,
  output logic signed [N-1:0]    value,
  output logic                   clamp
);

  localparam logic signed [N-1:0] YMAX =
    {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] YMIN =
    {1'b1, {(N-1){1'b0}}};

  logic signed [W_IN-1:0] sh;
  logic [W_IN-N:0]        top;
  logic                   fits;

  assign sh   = In >>> F;
  assign top  = sh[W_IN-1:N-1];
  assign fits = (&top) | (~|top);

  // Value fits when all bits above the sample are sign copies.
  always_comb begin
    clamp = ~fits;
    value = sh[N-1:0];
    if (!fits) begin
      value = sh[W_IN-1] ? YMIN : YMAX;
    end
  end

endmodule

// File: rtl/registro_historia_y.sv
// registro_historia_y: M-deep shift history of converted
// output samples with fill count and saturation flags.
module registro_historia_y
  import filtro_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int W_IN = W_IN_DEF,
  parameter int F    = F_DEF,
  parameter int M    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [W_IN-1:0]    In,
  input  logic                      Finish,
  input  logic                      Limpiar,
  output logic signed [N-1:0]       Yk,
  output logic [M*N-1:0]            Hist,
  output logic [$clog2(M+1)-1:0]    Cuenta,
  output logic                      Lleno,
  output logic                      Sat,
  output logic                      Desborde
);

  localparam int CW = $clog2(M+1);
  localparam logic [CW-1:0] CMAX = CW'(M);

  logic signed [N-1:0] slot [M];
  logic signed [N-1:0] conv;
  logic                clp;

  saturador_yk #(
    .N    (N),
    .W_IN (W_IN),
    .F    (F)
  ) u_sat (
    .In    (In),
    .value (conv),
    .clamp (clp)
  );

  // History shift, fill count and saturation flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < M; j++) slot[j] <= '0;
      Cuenta   <= '0;
      Sat      <= 1'b0;
      Desborde <= 1'b0;
    end else if (Limpiar) begin
      for (int j = 0; j < M; j++) slot[j] <= '0;
      Cuenta   <= '0;
      Sat      <= 1'b0;
      Desborde <= 1'b0;
    end else if (Finish) begin
      slot[0] <= conv;
      for (int j = 1; j < M; j++) slot[j] <= slot[j-1];
      if (Cuenta != CMAX) Cuenta <= Cuenta + CW'(1);
      Sat      <= clp;
      Desborde <= Desborde | clp;
    end else begin
      Sat <= 1'b0;
    end
  end

  for (genvar j = 0; j < M; j++) begin : g_hist
    assign Hist[j*N +: N] = slot[j];
  end

  assign Yk    = slot[0];
  assign Lleno = (Cuenta == CMAX);

endmodule

// File: tb/tb_registro_historia_y.sv
// tb_registro_historia_y: directed and random checks of the
// output history register against a queue-based model.
module tb_registro_historia_y;

  localparam int N = 8;
  localparam int W_IN = 16;
  localparam int F = 4;
  localparam int M = 3;

  logic clk = 0;
  logic rst_n = 0;
  logic signed [W_IN-1:0] In = '0;
  logic Finish = 0;
  logic Limpiar = 0;
  logic signed [N-1:0] Yk;
  logic [M*N-1:0] Hist;
  logic [1:0] Cuenta;
  logic Lleno, Sat, Desborde;

  int checks = 0;
  int errors = 0;

  int mq[$];
  int mcnt;
  bit msat, mdes;

  registro_historia_y #(
    .N(N), .W_IN(W_IN), .F(F), .M(M)
  ) dut (
    .clk(clk), .rst_n(rst_n), .In(In),
    .Finish(Finish), .Limpiar(Limpiar),
    .Yk(Yk), .Hist(Hist), .Cuenta(Cuenta),
    .Lleno(Lleno), .Sat(Sat), .Desborde(Desborde)
  );

  always #5 clk = ~clk;

  function automatic void conv(input logic [15:0] raw,
                               output int v, output bit c);
    int x, q, d;
    x = int'($signed(raw));
    d = 2 ** F;
    q = (x < 0) ? -((-x + d - 1) / d) : x / d;
    c = 0;
    v = q;
    if (q > 127) begin v = 127; c = 1; end
    if (q < -128) begin v = -128; c = 1; end
  endfunction

  function automatic logic [M*N-1:0] exp_hist();
    logic [M*N-1:0] h;
    int t;
    for (int j = 0; j < M; j++) begin
      t = mq[j];
      h[j*N +: N] = t[N-1:0];
    end
    return h;
  endfunction

  task automatic model_clear();
    mq = {0, 0, 0};
    mcnt = 0;
    msat = 0;
    mdes = 0;
  endtask

  task automatic step(input logic [15:0] raw,
                      input logic fin, input logic lim);
    int v;
    bit c;
    In = raw;
    Finish = fin;
    Limpiar = lim;
    @(posedge clk);
    if (lim) model_clear();
    else if (fin) begin
      conv(raw, v, c);
      mq.push_front(v);
      void'(mq.pop_back());
      if (mcnt < M) mcnt++;
      msat = c;
      mdes = mdes | c;
    end else msat = 0;
    #1;
    Finish = 0;
    Limpiar = 0;
  endtask

  task automatic test_reset();
    model_clear();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({Yk, Hist, Cuenta, Lleno, Sat, Desborde} !== '0) begin
      errors++;
      $display("FAIL reset: yk=%0d hist=%h cnt=%0d sat=%b des=%b want 0",
               Yk, Hist, Cuenta, Sat, Desborde);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_basic();
    step(16'h0150, 1, 0);
    checks++;
    if (Yk !== 8'sd21 || Cuenta !== 2'd1 || Sat !== 1'b0) begin
      errors++;
      $display("FAIL basic: yk=%0d cnt=%0d sat=%b want 21 1 0",
               Yk, Cuenta, Sat);
    end
    step(16'h0000, 0, 0);
    checks++;
    if (Yk !== 8'sd21 || Cuenta !== 2'd1) begin
      errors++;
      $display("FAIL hold: yk=%0d cnt=%0d want 21 1", Yk, Cuenta);
    end
  endtask

  task automatic test_floor_sat();
    step(16'hFFEF, 1, 0);
    checks++;
    if (Yk !== -8'sd2 || Sat !== 1'b0 || Desborde !== 1'b0) begin
      errors++;
      $display("FAIL floor: yk=%0d sat=%b des=%b want -2 0 0",
               Yk, Sat, Desborde);
    end
    step(16'h7FF0, 1, 0);
    checks++;
    if (Yk !== 8'sd127 || Sat !== 1'b1 || Desborde !== 1'b1) begin
      errors++;
      $display("FAIL satpos: yk=%0d sat=%b des=%b want 127 1 1",
               Yk, Sat, Desborde);
    end
    step(16'h0000, 0, 0);
    checks++;
    if (Sat !== 1'b0 || Desborde !== 1'b1) begin
      errors++;
      $display("FAIL satpulse: sat=%b des=%b want 0 1", Sat, Desborde);
    end
    step(16'h8000, 1, 0);
    checks++;
    if (Yk !== -8'sd128 || Sat !== 1'b1) begin
      errors++;
      $display("FAIL satneg: yk=%0d sat=%b want -128 1", Yk, Sat);
    end
  endtask

  task automatic test_clear_priority();
    step(16'h0010, 1, 1);
    checks++;
    if (Hist !== '0 || Cuenta !== 2'd0 || Desborde !== 1'b0 ||
        Sat !== 1'b0) begin
      errors++;
      $display("FAIL clear: hist=%h cnt=%0d des=%b sat=%b want 0",
               Hist, Cuenta, Desborde, Sat);
    end
  endtask

  task automatic test_back_to_back();
    step(16'd16, 1, 0);
    step(16'd32, 1, 0);
    step(16'd48, 1, 0);
    checks++;
    if (Hist !== {8'd1, 8'd2, 8'd3} || Lleno !== 1'b1 ||
        Cuenta !== 2'd3) begin
      errors++;
      $display("FAIL fill: hist=%h lleno=%b cnt=%0d want 010203 1 3",
               Hist, Lleno, Cuenta);
    end
    step(16'd64, 1, 0);
    checks++;
    if (Hist !== {8'd2, 8'd3, 8'd4} || Cuenta !== 2'd3) begin
      errors++;
      $display("FAIL shift: hist=%h cnt=%0d want 020304 3",
               Hist, Cuenta);
    end
  endtask

  task automatic test_limits();
    step(16'h0000, 0, 1);
    step(16'h07F0, 1, 0);
    checks++;
    if (Yk !== 8'sd127 || Sat !== 1'b0 || Desborde !== 1'b0) begin
      errors++;
      $display("FAIL limhi: yk=%0d sat=%b des=%b want 127 0 0",
               Yk, Sat, Desborde);
    end
    step(16'hF800, 1, 0);
    checks++;
    if (Yk !== -8'sd128 || Sat !== 1'b0 || Desborde !== 1'b0) begin
      errors++;
      $display("FAIL limlo: yk=%0d sat=%b des=%b want -128 0 0",
               Yk, Sat, Desborde);
    end
  endtask

  task automatic test_async_reset();
    step(16'h0100, 1, 0);
    step(16'h0200, 1, 0);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({Yk, Hist, Cuenta, Lleno, Sat, Desborde} !== '0) begin
      errors++;
      $display("FAIL asyncrst: hist=%h cnt=%0d want 0", Hist, Cuenta);
    end
    In = 16'h0300;
    Finish = 1;
    @(posedge clk);
    #1;
    Finish = 0;
    checks++;
    if (Cuenta !== 2'd0 || Hist !== '0) begin
      errors++;
      $display("FAIL rstload: hist=%h cnt=%0d want 0", Hist, Cuenta);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1;
    #1;
    step(16'h0300, 1, 0);
    checks++;
    if (Cuenta !== 2'd1 || Yk !== 8'sd48) begin
      errors++;
      $display("FAIL postrst: yk=%0d cnt=%0d want 48 1", Yk, Cuenta);
    end
  endtask

  task automatic test_random();
    logic [15:0] r;
    logic fin, lim;
    for (int i = 0; i < 300; i++) begin
      r = 16'($urandom);
      if (i % 4 == 0) r = {{5{r[15]}}, r[10:0]};
      fin = ($urandom_range(0, 3) != 0);
      lim = ($urandom_range(0, 19) == 0);
      step(r, fin, lim);
      checks++;
      if (Hist !== exp_hist() || Yk !== 8'(mq[0]) ||
          Cuenta !== 2'(mcnt) || Lleno !== (mcnt == M) ||
          Sat !== msat || Desborde !== mdes) begin
        errors++;
        $display("FAIL rand%0d: hist=%h cnt=%0d sat=%b des=%b want %h %0d %b %b",
                 i, Hist, Cuenta, Sat, Desborde,
                 exp_hist(), mcnt, msat, mdes);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_floor_sat();
    test_clear_priority();
    test_back_to_back();
    test_limits();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
